// File: rtl/axi_pkg.sv
// Shared constants and types for the AXI3 SRAM responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only 32-bit beats are supported.
  localparam logic [2:0] SIZE_4B = 3'b010;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    StIdle,
    StRdFetch,
    StRdBeat,
    StWrData,
    StWrResp
  } slv_state_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle (no lock/cache/prot) between the core master and the SRAM responder.
interface axi_sram_slave_if #(
  parameter int unsigned ADDR_W = 32
);

  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [3:0]        rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [3:0]        awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [3:0]        wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/sram_1rw.sv
// Single-port 32-bit SRAM: byte write enables, write-first, registered read data.
module sram_1rw #(
  parameter int unsigned Words = 16384,
  parameter int unsigned AddrW = $clog2(Words)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [AddrW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [Words];
  logic [31:0] merged;

  // Current word with the enabled bytes replaced; also the write-first read value.
  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Array update and output register; contents are never reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= merged;
      end
      rdata <= merged;
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder serving one INCR/FIXED burst (up to 16 beats) at a time from an internal SRAM.
// Optional build macro AXI_SLV_RAND_STALL_EN adds LFSR-driven random stalls on all channels.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MEM_WORDS = 16384,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h1c00_0000)
) (
  input logic             aclk,
  input logic             areset,
  axi_sram_slave_if.slave bus
);

  localparam int unsigned       IdxW     = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] WinBytes = ADDR_W'(4 * MEM_WORDS);
  localparam logic              RrRead   = 1'b0;
  localparam logic              RrWrite  = 1'b1;

  function automatic logic out_of_window(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off >= WinBytes;
  endfunction

  function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic [1:0] burst,
                                    input logic [2:0] size);
    return out_of_window(a) || !(burst == BURST_FIXED || burst == BURST_INCR) || size != SIZE_4B;
  endfunction

  slv_state_t        state_q, state_d;
  logic [3:0]        id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;
  logic              rr_last_q, rr_last_d;
  logic              rvalid_q, rvalid_d;
  logic              bvalid_q, bvalid_d;

  logic              stall;
  logic              ar_rdy, aw_rdy, w_rdy;
  logic              last_beat, beat_err;
  logic [ADDR_W-1:0] next_addr;

  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_byte_addr, mem_off;
  logic [31:0]       mem_rdata;

`ifdef AXI_SLV_RAND_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1); ~25% of cycles stall.
  always_ff @(posedge aclk) begin
    if (areset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign last_beat = (cnt_q == len_q);
  assign next_addr = (burst_q == BURST_INCR) ? addr_q + ADDR_W'(4) : addr_q;

  // Next-state, handshakes and SRAM port control.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    burst_d       = burst_q;
    err_d         = err_q;
    rr_last_d     = rr_last_q;
    rvalid_d      = rvalid_q;
    bvalid_d      = bvalid_q;
    ar_rdy        = 1'b0;
    aw_rdy        = 1'b0;
    w_rdy         = 1'b0;
    beat_err      = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_be        = 4'b0000;
    mem_byte_addr = addr_q;

    unique case (state_q)
      StIdle: begin
        // On a tie the channel not served last wins, so only one ready is ever high.
        ar_rdy = !areset && !stall && (!bus.awvalid || rr_last_q == RrWrite);
        aw_rdy = !areset && !stall && (!bus.arvalid || rr_last_q == RrRead);
        if (bus.arvalid && ar_rdy) begin
          id_d      = bus.arid;
          addr_d    = bus.araddr;
          len_d     = bus.arlen[3:0];
          burst_d   = bus.arburst;
          cnt_d     = 4'd0;
          err_d     = addr_err(bus.araddr, bus.arburst, bus.arsize);
          rr_last_d = RrRead;
          state_d   = StRdFetch;
        end else if (bus.awvalid && aw_rdy) begin
          id_d      = bus.awid;
          addr_d    = bus.awaddr;
          len_d     = bus.awlen[3:0];
          burst_d   = bus.awburst;
          cnt_d     = 4'd0;
          err_d     = addr_err(bus.awaddr, bus.awburst, bus.awsize);
          rr_last_d = RrWrite;
          state_d   = StWrData;
        end
      end

      StRdFetch: begin
        mem_en   = 1'b1;
        err_d    = err_q | out_of_window(addr_q);
        rvalid_d = !stall;
        state_d  = StRdBeat;
      end

      StRdBeat: begin
        if (!rvalid_q) begin
          rvalid_d = !stall;
        end else if (bus.rready) begin
          if (last_beat) begin
            rvalid_d = 1'b0;
            state_d  = StIdle;
          end else begin
            // Fetch the next beat now so beats stream at one per cycle.
            cnt_d         = cnt_q + 4'd1;
            addr_d        = next_addr;
            mem_en        = 1'b1;
            mem_byte_addr = next_addr;
            err_d         = err_q | out_of_window(next_addr);
            rvalid_d      = !stall;
          end
        end
      end

      StWrData: begin
        w_rdy = !areset && !stall;
        if (bus.wvalid && w_rdy) begin
          beat_err = err_q | out_of_window(addr_q);
          mem_en   = !beat_err;
          mem_we   = !beat_err;
          mem_be   = bus.wstrb;
          err_d    = beat_err;
          if (bus.wlast || last_beat) begin
            // wlast disagreeing with the beat count poisons the response.
            if (bus.wlast != last_beat) begin
              err_d = 1'b1;
            end
            bvalid_d = !stall;
            state_d  = StWrResp;
          end else begin
            cnt_d  = cnt_q + 4'd1;
            addr_d = next_addr;
          end
        end
      end

      StWrResp: begin
        if (!bvalid_q) begin
          bvalid_d = !stall;
        end else if (bus.bready) begin
          bvalid_d = 1'b0;
          state_d  = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any burst without touching the SRAM.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= StIdle;
      id_q      <= 4'd0;
      addr_q    <= '0;
      len_q     <= 4'd0;
      cnt_q     <= 4'd0;
      burst_q   <= BURST_FIXED;
      err_q     <= 1'b0;
      rr_last_q <= RrWrite;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      rr_last_q <= rr_last_d;
      rvalid_q  <= rvalid_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign mem_off = mem_byte_addr - BASE_ADDR;

  sram_1rw #(
    .Words (MEM_WORDS),
    .AddrW (IdxW)
  ) u_sram (
    .clk   (aclk),
    .en    (mem_en && !areset),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_off[IdxW+1:2]),
    .wdata (bus.wdata),
    .rdata (mem_rdata)
  );

  assign bus.arready = ar_rdy;
  assign bus.awready = aw_rdy;
  assign bus.wready  = w_rdy;
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = id_q;
  assign bus.rdata   = (rvalid_q && !err_q) ? mem_rdata : 32'd0;
  assign bus.rresp   = (rvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign bus.rlast   = rvalid_q && last_beat;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = id_q;
  assign bus.bresp   = (bvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;

  logic unused_bits;
  assign unused_bits = ^{bus.wid, bus.arlen[7:4], bus.awlen[7:4], mem_off[1:0],
                         mem_off[ADDR_W-1:IdxW+2]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave (default build, no random stalls).
module tb_axi_sram_slave;
  import axi_pkg::*;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [31:0] wdat [16];
  logic [3:0]  wstrb_v = 4'hf;
  logic [31:0] exp_data [16];
  logic [1:0]  exp_resp [16];
  int          first_wait;

  always #5 aclk = ~aclk;

  axi_sram_slave_if #(.ADDR_W(32)) bus ();

  axi_sram_slave #(
    .ADDR_W    (32),
    .MEM_WORDS (16384),
    .BASE_ADDR (32'h1c00_0000)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    #1;
    while (!bus.arready && n < 20) begin @(posedge aclk); #2; n++; end
    if (!bus.arready) check("ar_timeout", 32'd0, 32'd1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    #1;
    while (!bus.awready && n < 20) begin @(posedge aclk); #2; n++; end
    if (!bus.awready) check("aw_timeout", 32'd0, 32'd1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  // Sends nb beats from wdat[], with wlast on beat last_at.
  task automatic write_beats(input int nb, input int last_at);
    for (int b = 0; b < nb; b++) begin
      int n = 0;
      bus.wvalid = 1'b1; bus.wdata = wdat[b]; bus.wstrb = wstrb_v; bus.wlast = (b == last_at);
      #1;
      while (!bus.wready && n < 20) begin @(posedge aclk); #2; n++; end
      if (!bus.wready) begin
        check("w_timeout", 32'd0, 32'd1);
        bus.wvalid = 1'b0;
        @(posedge aclk); #1;
        return;
      end
      @(posedge aclk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] resp, input logic [3:0] id);
    int n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!bus.bvalid) begin
      check("b_timeout", 32'd0, 32'd1);
      bus.bready = 1'b0;
      return;
    end
    check("bresp", 32'(bus.bresp), 32'(resp));
    check("bid", 32'(bus.bid), 32'(id));
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    check("b_done", 32'(bus.bvalid), 32'd0);
  endtask

  // Collects nb beats against exp_data/exp_resp; holds rready low 3 cycles on hold_beat.
  task automatic read_beats(input int nb, input logic [3:0] id, input int hold_beat,
                            output int wait0);
    logic [31:0] d0;
    logic        l0;
    wait0 = -1;
    bus.rready = 1'b1;
    for (int b = 0; b < nb; b++) begin
      int n = 0;
      while (!bus.rvalid && n < 20) begin @(posedge aclk); #1; n++; end
      if (b == 0) wait0 = n;
      if (!bus.rvalid) begin
        check("r_timeout", 32'd0, 32'd1);
        bus.rready = 1'b0;
        return;
      end
      if (b == hold_beat) begin
        bus.rready = 1'b0;
        d0 = bus.rdata;
        l0 = bus.rlast;
        repeat (3) begin
          @(posedge aclk); #1;
          check("hold_valid", 32'(bus.rvalid), 32'd1);
          check("hold_data", bus.rdata, d0);
          check("hold_last", 32'(bus.rlast), 32'(l0));
        end
        bus.rready = 1'b1;
      end
      check("rdata", bus.rdata, exp_data[b]);
      check("rresp", 32'(bus.rresp), 32'(exp_resp[b]));
      check("rlast", 32'(bus.rlast), 32'(b == nb - 1));
      check("rid", 32'(bus.rid), 32'(id));
      @(posedge aclk); #1;
    end
    bus.rready = 1'b0;
    check("r_done", 32'(bus.rvalid), 32'd0);
  endtask

  task automatic set_exp(input int nb, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3, input logic [1:0] resp);
    exp_data[0] = d0; exp_data[1] = d1; exp_data[2] = d2; exp_data[3] = d3;
    for (int i = 0; i < nb; i++) exp_resp[i] = resp;
  endtask

  initial begin
    bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.arvalid = 0; bus.rready = 0;
    bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.awvalid = 0; bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
    bus.wvalid = 0; bus.bready = 0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("reset_outs", 32'({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.rlast,
                             bus.rresp, bus.bvalid, bus.bresp}), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    areset = 1'b0;
    @(posedge aclk); #1;

    // 1: INCR write then read back
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
    wstrb_v = 4'hf;
    send_aw(4'd5, 32'h1c00_0000, 8'd3, 3'b010, BURST_INCR);
    write_beats(4, 3);
    wait_b(RESP_OKAY, 4'd5);
    send_ar(4'd9, 32'h1c00_0000, 8'd3, 3'b010, BURST_INCR);
    check("r_t1_idle", 32'(bus.rvalid), 32'd0);
    set_exp(4, 32'h11, 32'h22, 32'h33, 32'h44, RESP_OKAY);
    read_beats(4, 4'd9, -1, first_wait);
    check("r_latency", 32'(first_wait), 32'd1);

    // 2: partial strobe
    wdat[0] = 32'hffff_ffff; wstrb_v = 4'hf;
    send_aw(4'd1, 32'h1c00_0010, 8'd0, 3'b010, BURST_INCR);
    write_beats(1, 0);
    wait_b(RESP_OKAY, 4'd1);
    wdat[0] = 32'h0000_ab00; wstrb_v = 4'b0010;
    send_aw(4'd1, 32'h1c00_0010, 8'd0, 3'b010, BURST_INCR);
    write_beats(1, 0);
    wait_b(RESP_OKAY, 4'd1);
    wstrb_v = 4'hf;
    send_ar(4'd1, 32'h1c00_0010, 8'h00, 3'b010, BURST_INCR);
    set_exp(1, 32'hffff_abff, 0, 0, 0, RESP_OKAY);
    read_beats(1, 4'd1, -1, first_wait);

    // 3: R backpressure mid-burst; arlen[7:4] truncated
    send_ar(4'd3, 32'h1c00_0000, 8'hf3, 3'b010, BURST_INCR);
    set_exp(4, 32'h11, 32'h22, 32'h33, 32'h44, RESP_OKAY);
    read_beats(4, 4'd3, 2, first_wait);

    // 4: simultaneous AR/AW from reset -> read first, then write
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    bus.arid = 4'd7; bus.araddr = 32'h1c00_0000; bus.arlen = 0; bus.arsize = 3'b010;
    bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    bus.awid = 4'd8; bus.awaddr = 32'h1c00_0020; bus.awlen = 0; bus.awsize = 3'b010;
    bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    #1;
    check("arb1_ar", 32'(bus.arready), 32'd1);
    check("arb1_aw", 32'(bus.awready), 32'd0);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    set_exp(1, 32'h11, 0, 0, 0, RESP_OKAY);
    read_beats(1, 4'd7, -1, first_wait);
    bus.arvalid = 1'b1;
    #1;
    check("arb2_aw", 32'(bus.awready), 32'd1);
    check("arb2_ar", 32'(bus.arready), 32'd0);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    wdat[0] = 32'h5a5a_5a5a;
    write_beats(1, 0);
    wait_b(RESP_OKAY, 4'd8);
    send_ar(4'd7, 32'h1c00_0020, 8'd0, 3'b010, BURST_INCR);
    set_exp(1, 32'h5a5a_5a5a, 0, 0, 0, RESP_OKAY);
    read_beats(1, 4'd7, -1, first_wait);

    // 5a: read outside window
    send_ar(4'd3, 32'h0000_0000, 8'd1, 3'b010, BURST_INCR);
    set_exp(2, 0, 0, 0, 0, RESP_SLVERR);
    read_beats(2, 4'd3, -1, first_wait);

    // 5b: reserved burst type writes nothing
    wdat[0] = 32'hdead_beef;
    send_aw(4'd4, 32'h1c00_0000, 8'd0, 3'b010, 2'b10);
    write_beats(1, 0);
    wait_b(RESP_SLVERR, 4'd4);
    send_ar(4'd4, 32'h1c00_0000, 8'd0, 3'b010, BURST_INCR);
    set_exp(1, 32'h11, 0, 0, 0, RESP_OKAY);
    read_beats(1, 4'd4, -1, first_wait);

    // 5c: early wlast
    wdat[0] = 32'h1; wdat[1] = 32'h2;
    send_aw(4'd6, 32'h1c00_0040, 8'd3, 3'b010, BURST_INCR);
    write_beats(2, 1);
    wait_b(RESP_SLVERR, 4'd6);

    // 5d: INCR read crossing the window top errors from the crossing beat on
    wdat[0] = 32'ha1; wdat[1] = 32'ha2;
    send_aw(4'd2, 32'h1c00_fff8, 8'd1, 3'b010, BURST_INCR);
    write_beats(2, 1);
    wait_b(RESP_OKAY, 4'd2);
    send_ar(4'd2, 32'h1c00_fff8, 8'd3, 3'b010, BURST_INCR);
    set_exp(4, 32'ha1, 32'ha2, 0, 0, RESP_OKAY);
    exp_resp[2] = RESP_SLVERR; exp_resp[3] = RESP_SLVERR;
    read_beats(4, 4'd2, -1, first_wait);

    // 5e: FIXED burst rereads the same word
    send_ar(4'd1, 32'h1c00_0004, 8'd2, 3'b010, BURST_FIXED);
    set_exp(3, 32'h22, 32'h22, 32'h22, 0, RESP_OKAY);
    read_beats(3, 4'd1, -1, first_wait);

    // 6: reset mid-read, then contents retained
    send_ar(4'd2, 32'h1c00_0000, 8'd3, 3'b010, BURST_INCR);
    bus.rready = 1'b0;
    @(posedge aclk); #1;
    check("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
    areset = 1'b1;
    @(posedge aclk); #1;
    check("rst_valids", 32'({bus.rvalid, bus.bvalid, bus.wready}), 32'd0);
    areset = 1'b0;
    @(posedge aclk); #1;
    #1;
    check("rst_idle", 32'({bus.arready, bus.awready}), 32'b11);
    @(posedge aclk); #1;
    send_ar(4'd2, 32'h1c00_0000, 8'd3, 3'b010, BURST_INCR);
    set_exp(4, 32'h11, 32'h22, 32'h33, 32'h44, RESP_OKAY);
    read_beats(4, 4'd2, -1, first_wait);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
